// File: rtl/path_control_if.sv
// path_control_if: instruction-field and control-word bundle between the
// instruction register / datapath side (master) and the decoder (slave).
interface path_control_if;
    logic        en;
    logic [3:0]  opcode;
    logic [3:0]  functcode;
    logic [13:0] control;
    logic        illegal;
    logic        halted;

    modport master (
        output en,
        output opcode,
        output functcode,
        input  control,
        input  illegal,
        input  halted
    );

    modport slave (
        input  en,
        input  opcode,
        input  functcode,
        output control,
        output illegal,
        output halted
    );
endinterface

// File: rtl/path_control.sv
// path_control: registered main-control decoder for the 16-bit teaching CPU.
// Turns opcode/functcode into a 14-bit datapath control word one cycle later,
// with an illegal-instruction flag and a sticky halt.
//
// Build option: define ILLEGAL_HALT_EN to make an illegal instruction halt the
// core (control = 2007, illegal = 1, both sticky until reset). Without it an
// illegal instruction yields NOP_WORD with illegal set for that capture only.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | decoding; each enabled edge captures a new control word
// ST_HALT | halted; control word and illegal flag frozen until reset
module path_control #(
    parameter logic [13:0] NOP_WORD = 14'h0007
) (
    input logic          clk,
    input logic          rst_n,
    path_control_if.slave bus
);

    localparam logic [13:0] HALT_WORD = 14'h2007;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] control_q, control_d;
    logic        illegal_q, illegal_d;

    logic [13:0] dec_word;
    logic        dec_legal;
    logic        dec_halt;

    // Pure instruction decode; functcode only matters for opcode 0000.
    always_comb begin
        dec_word  = NOP_WORD;
        dec_legal = 1'b1;
        dec_halt  = 1'b0;
        case (bus.opcode)
            4'h0: begin
                case (bus.functcode)
                    4'h0:    dec_word = 14'h0040;
                    4'h1:    dec_word = 14'h0041;
                    4'h4:    dec_word = 14'h004A;
                    4'h8:    dec_word = 14'h004B;
                    4'hE:    dec_word = 14'h0046;
                    4'hF:    dec_word = 14'h004E;
                    default: dec_legal = 1'b0;
                endcase
            end
            4'h1:    dec_word = 14'h0054;
            4'h2:    dec_word = 14'h0055;
            4'h4:    dec_word = 14'h0401;
            4'h5:    dec_word = 14'h0801;
            4'h6:    dec_word = 14'h0C01;
            4'h8:    dec_word = 14'h02F0;
            4'h9:    dec_word = 14'h0190;
            4'hA:    dec_word = 14'h0270;
            4'hB:    dec_word = 14'h0110;
            4'hC:    dec_word = 14'h1007;
            4'hF: begin
                dec_word = HALT_WORD;
                dec_halt = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state and next-output logic; holding is the default so en = 0 and
    // the halted state need no explicit branches for their outputs.
    always_comb begin
        state_d   = state_q;
        control_d = control_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_RUN: begin
                if (bus.en) begin
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
`ifdef ILLEGAL_HALT_EN
                        control_d = HALT_WORD;
                        state_d   = ST_HALT;
`else
                        control_d = NOP_WORD;
`endif
                    end else begin
                        illegal_d = 1'b0;
                        control_d = dec_word;
                        if (dec_halt) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d   = ST_RUN;
                control_d = NOP_WORD;
                illegal_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the idle NOP word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            control_q <= NOP_WORD;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            control_q <= control_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.control = control_q;
    assign bus.illegal = illegal_q;
    assign bus.halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_path_control.sv
// tb_path_control: directed and randomized checks of path_control against a
// table-driven reference model of the instruction set.
`timescale 1ns/1ps
module tb_path_control;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    path_control_if bus ();

    path_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-opcode word table plus a functcode map for opcode 0.
    logic [13:0] op_word [16];
    bit          op_ok   [16];
    logic [13:0] fn_word [int];

    logic [13:0] m_ctl;
    bit          m_ill;
    bit          m_halt;

    function automatic void model_init();
        for (int i = 0; i < 16; i++) begin
            op_word[i] = 14'h0007;
            op_ok[i]   = 1'b0;
        end
        op_word[1]  = 14'h0054; op_ok[1]  = 1'b1;
        op_word[2]  = 14'h0055; op_ok[2]  = 1'b1;
        op_word[4]  = 14'h0401; op_ok[4]  = 1'b1;
        op_word[5]  = 14'h0801; op_ok[5]  = 1'b1;
        op_word[6]  = 14'h0C01; op_ok[6]  = 1'b1;
        op_word[8]  = 14'h02F0; op_ok[8]  = 1'b1;
        op_word[9]  = 14'h0190; op_ok[9]  = 1'b1;
        op_word[10] = 14'h0270; op_ok[10] = 1'b1;
        op_word[11] = 14'h0110; op_ok[11] = 1'b1;
        op_word[12] = 14'h1007; op_ok[12] = 1'b1;
        op_word[15] = 14'h2007; op_ok[15] = 1'b1;
        fn_word[0]  = 14'h0040;
        fn_word[1]  = 14'h0041;
        fn_word[4]  = 14'h004A;
        fn_word[8]  = 14'h004B;
        fn_word[14] = 14'h0046;
        fn_word[15] = 14'h004E;
    endfunction

    function automatic void model_reset();
        m_ctl  = 14'h0007;
        m_ill  = 1'b0;
        m_halt = 1'b0;
    endfunction

    function automatic void model_capture(input bit e, input int op, input int fc);
        bit          legal;
        logic [13:0] w;
        if (m_halt || !e) return;
        if (op == 0) begin
            legal = fn_word.exists(fc);
            w     = legal ? fn_word[fc] : 14'h0007;
        end else begin
            legal = op_ok[op];
            w     = op_word[op];
        end
        if (!legal) begin
            m_ill = 1'b1;
`ifdef ILLEGAL_HALT_EN
            m_ctl  = 14'h2007;
            m_halt = 1'b1;
`else
            m_ctl  = 14'h0007;
`endif
        end else begin
            m_ill = 1'b0;
            m_ctl = w;
            if (op == 15) m_halt = 1'b1;
        end
    endfunction

    // Apply one instruction between edges and advance the model after the edge.
    task automatic step(input bit e, input logic [3:0] op, input logic [3:0] fc);
        @(negedge clk);
        bus.en        = e;
        bus.opcode    = op;
        bus.functcode = fc;
        @(posedge clk);
        #1;
        model_capture(e, int'(op), int'(fc));
    endtask

    // Assert reset part-way through a cycle; caller checks before release.
    task automatic reset_mid_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'hA, 4'h0);
        reset_mid_cycle();
        n_checks++;
        if (bus.control !== 14'h0007) begin
            n_fail++;
            $display("FAIL reset_control: got %h expected 0007", bus.control);
        end
        n_checks++;
        if (bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_illegal: got %b expected 0", bus.illegal);
        end
        n_checks++;
        if (bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_halted: got %b expected 0", bus.halted);
        end
        release_reset();
    endtask

    task automatic test_sweep();
        logic [3:0]  ops [16];
        logic [3:0]  fcs [16];
        logic [13:0] exp [16];
        ops = '{4'hC, 4'h6, 4'h5, 4'h4, 4'hB, 4'hA, 4'h9, 4'h8,
                4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        fcs = '{4'h3, 4'h9, 4'h2, 4'h7, 4'h5, 4'hD, 4'h6, 4'h4,
                4'h8, 4'hE, 4'hF, 4'hE, 4'h8, 4'h4, 4'h1, 4'h0};
        exp = '{14'h1007, 14'h0C01, 14'h0801, 14'h0401, 14'h0110, 14'h0270,
                14'h0190, 14'h02F0, 14'h0055, 14'h0054, 14'h004E, 14'h0046,
                14'h004B, 14'h004A, 14'h0041, 14'h0040};
        for (int i = 0; i < 16; i++) begin
            step(1'b1, ops[i], fcs[i]);
            n_checks++;
            if (bus.control !== exp[i]) begin
                n_fail++;
                $display("FAIL sweep_control[%0d]: got %h expected %h", i, bus.control, exp[i]);
            end
            n_checks++;
            if (bus.illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_illegal[%0d]: got %b expected 0", i, bus.illegal);
            end
        end
    endtask

    task automatic test_illegal();
        logic [13:0] exp_ctl [3];
        bit          exp_ill [3];
        bit          exp_hlt [3];
        logic [3:0]  ops [3];
        logic [3:0]  fcs [3];
        ops = '{4'h0, 4'h7, 4'h0};
        fcs = '{4'h7, 4'hA, 4'h0};
`ifdef ILLEGAL_HALT_EN
        exp_ctl = '{14'h2007, 14'h2007, 14'h2007};
        exp_ill = '{1'b1, 1'b1, 1'b1};
        exp_hlt = '{1'b1, 1'b1, 1'b1};
`else
        exp_ctl = '{14'h0007, 14'h0007, 14'h0040};
        exp_ill = '{1'b1, 1'b1, 1'b0};
        exp_hlt = '{1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ops[i], fcs[i]);
            n_checks++;
            if (bus.control !== exp_ctl[i] || bus.illegal !== exp_ill[i] || bus.halted !== exp_hlt[i]) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got ctl=%h ill=%b hlt=%b expected ctl=%h ill=%b hlt=%b",
                         i, bus.control, bus.illegal, bus.halted, exp_ctl[i], exp_ill[i], exp_hlt[i]);
            end
        end
        reset_mid_cycle();
        release_reset();
    endtask

    task automatic test_halt();
        logic [3:0] ops [4];
        ops = '{4'hF, 4'h0, 4'hA, 4'h7};
        for (int i = 0; i < 4; i++) begin
            step((i != 3), ops[i], 4'h0);
            n_checks++;
            if (bus.control !== 14'h2007 || bus.halted !== 1'b1 || bus.illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL halt[%0d]: got ctl=%h hlt=%b ill=%b expected ctl=2007 hlt=1 ill=0",
                         i, bus.control, bus.halted, bus.illegal);
            end
        end
        // Reset during halt with the stage disabled.
        bus.en = 1'b0;
        reset_mid_cycle();
        n_checks++;
        if (bus.control !== 14'h0007 || bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: got ctl=%h hlt=%b ill=%b expected ctl=0007 hlt=0 ill=0",
                     bus.control, bus.halted, bus.illegal);
        end
        release_reset();
    endtask

    task automatic test_stall();
        bit          es  [3];
        logic [3:0]  ops [3];
        logic [13:0] exp [3];
        es  = '{1'b1, 1'b0, 1'b1};
        ops = '{4'hA, 4'hB, 4'hB};
        exp = '{14'h0270, 14'h0270, 14'h0110};
        for (int i = 0; i < 3; i++) begin
            step(es[i], ops[i], 4'h0);
            n_checks++;
            if (bus.control !== exp[i]) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h expected %h", i, bus.control, exp[i]);
            end
        end
        // Illegal flag also holds across a stall, then reset during the stall.
        step(1'b1, 4'h0, 4'h3);
        step(1'b0, 4'h0, 4'h0);
        n_checks++;
        if (bus.illegal !== m_ill || bus.control !== m_ctl) begin
            n_fail++;
            $display("FAIL stall_hold_illegal: got ctl=%h ill=%b expected ctl=%h ill=%b",
                     bus.control, bus.illegal, m_ctl, m_ill);
        end
        reset_mid_cycle();
        n_checks++;
        if (bus.control !== 14'h0007 || bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_reset: got ctl=%h hlt=%b ill=%b expected ctl=0007 hlt=0 ill=0",
                     bus.control, bus.halted, bus.illegal);
        end
        release_reset();
    endtask

    task automatic test_random();
        logic [3:0] fc_pick [8];
        logic [3:0] op;
        logic [3:0] fc;
        bit         e;
        fc_pick = '{4'h0, 4'h1, 4'h4, 4'h8, 4'hE, 4'hF, 4'h2, 4'h9};
        for (int i = 0; i < 400; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                reset_mid_cycle();
                n_checks++;
                if (bus.control !== m_ctl || bus.illegal !== m_ill || bus.halted !== m_halt) begin
                    n_fail++;
                    $display("FAIL random_reset[%0d]: got ctl=%h ill=%b hlt=%b expected ctl=%h ill=%b hlt=%b",
                             i, bus.control, bus.illegal, bus.halted, m_ctl, m_ill, m_halt);
                end
                release_reset();
            end
            e  = ($urandom_range(0, 4) != 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 2) != 0) op = 4'h0;
            fc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : fc_pick[$urandom_range(0, 7)];
            step(e, op, fc);
            n_checks++;
            if (bus.control !== m_ctl || bus.illegal !== m_ill || bus.halted !== m_halt) begin
                n_fail++;
                $display("FAIL random[%0d] en=%b op=%h fc=%h: got ctl=%h ill=%b hlt=%b expected ctl=%h ill=%b hlt=%b",
                         i, e, op, fc, bus.control, bus.illegal, bus.halted, m_ctl, m_ill, m_halt);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.en        = 1'b0;
        bus.opcode    = 4'h0;
        bus.functcode = 4'h0;
        model_init();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();

        test_reset();
        test_sweep();
        test_illegal();
        test_halt();
        test_stall();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
